// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// idle line level and a small index-width helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake bundle of the UART transmit scheduler:
// per-requester request/data in, one-hot grant and frame status out.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      done;

  modport master (
    output req,
    output req_data,
    input  gnt,
    input  busy,
    input  done
  );

  modport slave (
    input  req,
    input  req_data,
    output gnt,
    output busy,
    output done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or above
// rr_ptr (wrapping) and returns it both one-hot and as an index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  int                 w;

  always_comb begin
    // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the winner.
    rot    = NUM_REQ'({req, req} >> rr_ptr);
    any    = 1'b0;
    w      = 0;
    winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        w   = int'(rr_ptr) + k;
      end
    end
    if (w >= NUM_REQ) w = w - NUM_REQ;
    winner = IDX_W'(w);
    gnt    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      gnt[j] = any && (winner == IDX_W'(j));
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: grants one requester per frame, phase-aligns the
// external baud generator and frames bits on baud_clk falling edges. Optional even parity: UART_TX_PARITY_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic               Clock,
  input  logic               reset,
  uart_tx_scheduler_if.slave bus,
  input  logic               baud_clk,
  output logic               baud_rst,
  output logic               tx
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(DATA_W);

  tx_state_t          state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic               baud_clk_q;
  logic               baud_rst_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               stop_cnt;
  logic [DATA_W-1:0]  shift;
  logic [DATA_W-1:0]  shift_nxt;
  logic [DATA_W-1:0]  sel_data;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_winner;
  logic               arb_any;
  logic               fall;
  logic               last_bit;
  logic               last_stop;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt),
    .winner (arb_winner),
    .any    (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_data = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // A fall seen while the generator is being reset (or just after) is stale phase.
  assign fall      = baud_clk_q & ~baud_clk & ~(baud_rst | baud_rst_q);
  assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign shift_nxt = shift >> 1;
  assign next_ptr  = (arb_winner == IDX_W'(NUM_REQ - 1)) ? '0 : arb_winner + IDX_W'(1);

  always_ff @(posedge Clock) begin
    if (state == S_IDLE && arb_any) shift <= sel_data;
    else if (state == S_DATA && fall) shift <= shift_nxt;
  end

`ifdef UART_TX_PARITY_EN
  logic parity;
  always_ff @(posedge Clock) begin
    if (state == S_IDLE && arb_any) parity <= ^sel_data;
  end
`endif

  always_ff @(posedge Clock) begin
    if (reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      baud_clk_q <= 1'b0;
      baud_rst_q <= 1'b0;
      baud_rst   <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      tx         <= UART_IDLE_LEVEL;
      bus.gnt    <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.gnt    <= '0;
      bus.done   <= 1'b0;
      baud_rst   <= 1'b0;
      baud_rst_q <= baud_rst;
      baud_clk_q <= baud_rst ? 1'b0 : baud_clk;
      case (state)
        S_IDLE: begin
          tx <= UART_IDLE_LEVEL;
          if (arb_any) begin
            bus.gnt  <= arb_gnt;
            bus.busy <= 1'b1;
            baud_rst <= 1'b1;
            rr_ptr   <= next_ptr;
            state    <= S_START;
          end
        end
        S_START: begin
          // Line drops one cycle after the generator reset lands, matching the
          // one-cycle fall-detect lag so the start bit is a full baud period.
          tx <= baud_rst ? UART_IDLE_LEVEL : ~UART_IDLE_LEVEL;
          if (fall) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            tx      <= shift[0];
          end
        end
        S_DATA: begin
          if (fall) begin
            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity;
`else
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              tx       <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tx      <= shift_nxt[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (fall) begin
            state    <= S_STOP;
            stop_cnt <= 1'b0;
            tx       <= UART_IDLE_LEVEL;
          end
        end
`endif
        S_STOP: begin
          tx <= UART_IDLE_LEVEL;
          if (fall) begin
            if (last_stop) begin
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a local baud generator (8 Clock cycles per bit).
// Honours UART_TX_PARITY_EN when defined for the whole build.
module tb_uart_tx_scheduler;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BIT_CYC   = 8;
  localparam int FRAME_CYC = BIT_CYC * (1 + 8 + PAR + 1);
  localparam int GNT_BOUND = 300;

  logic Clock = 1'b0;
  logic reset;
  logic baud_clk;
  logic baud_rst;
  logic tx;
  logic [1:0] bcnt;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler_if #(.NUM_REQ(2), .DATA_W(8)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ   (2),
    .DATA_W    (8),
    .STOP_BITS (1)
  ) dut (
    .Clock    (Clock),
    .reset    (reset),
    .bus      (bus.slave),
    .baud_clk (baud_clk),
    .baud_rst (baud_rst),
    .tx       (tx)
  );

  always #5 Clock = ~Clock;

  // Baud generator, CLOCKS_WAIT=3: toggles every 4 cycles, output low after reset.
  always_ff @(posedge Clock) begin
    if (reset || baud_rst) begin
      bcnt     <= 2'd0;
      baud_clk <= 1'b0;
    end else if (bcnt == 2'd3) begin
      bcnt     <= 2'd0;
      baud_clk <= ~baud_clk;
    end else begin
      bcnt <= bcnt + 2'd1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Line level at cycle offset o of a frame carrying byte b (offset 0 = first start-bit cycle).
  function automatic logic exp_tx(input logic [7:0] b, input int o);
    int k;
    k = o / BIT_CYC;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Round-robin reference: first set request scanning upward from ptr with wrap.
  function automatic int rr_pick(input logic [1:0] r, input int ptr);
    for (int k = 0; k < 2; k++) begin
      if (r[(ptr + k) % 2]) return (ptr + k) % 2;
    end
    return -1;
  endfunction

  task automatic wait_gnt(input string name, input logic [1:0] exp_g, output int n);
    n = 0;
    while (bus.gnt === 2'b00 && n < GNT_BOUND) begin
      @(negedge Clock);
      n++;
    end
    check({name, "_gnt"}, bus.gnt, exp_g);
    if (bus.gnt !== 2'b00) begin
      check({name, "_baud_rst"}, baud_rst, 1'b1);
      check({name, "_busy_at_gnt"}, bus.busy, 1'b1);
    end
  endtask

  task automatic capture(input string name, input logic [7:0] eb, input int wig_at,
                         input logic [1:0] glitch, input logic [1:0] wreq, input logic [15:0] wdata);
    int n;
    int bad;
    int early_done;
    int stray_gnt;
    logic [7:0] got;
    n = 0; bad = 0; early_done = 0; stray_gnt = 0; got = '0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check({name, "_start_seen"}, tx, 1'b0);
    if (tx !== 1'b0) return;
    for (int o = 0; o < FRAME_CYC; o++) begin
      if (tx !== exp_tx(eb, o) || bus.busy !== 1'b1) bad++;
      if (bus.done !== 1'b0) early_done++;
      if (bus.gnt !== 2'b00) stray_gnt++;
      if (o % BIT_CYC == 4 && o / BIT_CYC >= 1 && o / BIT_CYC <= 8) got = {tx, got[7:1]};
      if (wig_at >= 0 && o == wig_at / 2) bus.req = glitch;
      if (wig_at >= 0 && o == wig_at) begin
        bus.req      = wreq;
        bus.req_data = wdata;
      end
      @(negedge Clock);
    end
    check({name, "_wave_bad_cycles"}, bad, 0);
    check({name, "_early_done"}, early_done, 0);
    check({name, "_gnt_while_busy"}, stray_gnt, 0);
    check({name, "_byte"}, got, eb);
    check({name, "_done_at_end"}, bus.done, 1'b1);
    check({name, "_busy_at_end"}, bus.busy, 1'b0);
  endtask

  typedef struct {
    int         delay;
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_gnt;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int m_ptr;
    int w;
    logic [1:0]  eg;
    logic [7:0]  eb;
    logic [1:0]  remaining;
    logic [1:0]  newbits;
    logic [1:0]  pend_req;
    logic [15:0] pend_data;
    logic [15:0] ndata;

    // Expected grants follow the rotating pointer starting at 0 after reset.
    vecs[0] = '{0, 2'b01, 8'h55, 8'h00, 2'b01, 8'h55};
    vecs[1] = '{3, 2'b01, 8'hC3, 8'h00, 2'b01, 8'hC3};
    vecs[2] = '{1, 2'b11, 8'hA0, 8'h0F, 2'b10, 8'h0F};
    vecs[3] = '{5, 2'b11, 8'hA0, 8'h0F, 2'b01, 8'hA0};
    vecs[4] = '{2, 2'b10, 8'h00, 8'h3C, 2'b10, 8'h3C};
    vecs[5] = '{7, 2'b10, 8'h00, 8'h81, 2'b10, 8'h81};
    vecs[6] = '{4, 2'b11, 8'hFF, 8'h00, 2'b01, 8'hFF};
    vecs[7] = '{6, 2'b11, 8'hFF, 8'h00, 2'b10, 8'h00};

    reset        = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(negedge Clock);
    reset = 1'b0;
    @(negedge Clock);
    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_baud_rst", baud_rst, 1'b0);

    for (int i = 0; i < 8; i++) begin
      repeat (vecs[i].delay) @(negedge Clock);
      bus.req      = vecs[i].req;
      bus.req_data = {vecs[i].d1, vecs[i].d0};
      wait_gnt($sformatf("vec%0d", i), vecs[i].exp_gnt, n);
      bus.req = '0;
      @(negedge Clock);
      check($sformatf("vec%0d_baud_rst_pulse", i), baud_rst, 1'b0);
      check($sformatf("vec%0d_tx_mask_cycle", i), tx, 1'b1);
      capture($sformatf("vec%0d", i), vecs[i].exp_byte, -1, 2'b00, 2'b00, 16'h0);
    end

    // Two requesters held continuously: alternate, each grant one cycle after done.
    bus.req      = 2'b11;
    bus.req_data = {8'h0F, 8'hA0};
    wait_gnt("hold0", 2'b01, n);
    capture("hold0", 8'hA0, -1, 2'b00, 2'b00, 16'h0);
    wait_gnt("hold1", 2'b10, n);
    check("hold1_gap", n, 1);
    capture("hold1", 8'h0F, -1, 2'b00, 2'b00, 16'h0);
    wait_gnt("hold2", 2'b01, n);
    check("hold2_gap", n, 1);
    bus.req = '0;
    capture("hold2", 8'hA0, -1, 2'b00, 2'b00, 16'h0);

    // Requester 1 raised mid-frame waits for done.
    bus.req      = 2'b01;
    bus.req_data = {8'h00, 8'h3C};
    wait_gnt("mid0", 2'b01, n);
    bus.req = '0;
    capture("mid0", 8'h3C, 30, 2'b00, 2'b10, {8'h96, 8'h3C});
    wait_gnt("mid1", 2'b10, n);
    check("mid1_gap", n, 1);
    bus.req = '0;
    capture("mid1", 8'h96, -1, 2'b00, 2'b00, 16'h0);

    // Reset during data bit 3 aborts the frame and restarts the pointer at 0.
    bus.req      = 2'b11;
    bus.req_data = {8'hE7, 8'h5A};
    wait_gnt("abort", 2'b01, n);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      @(negedge Clock);
      n++;
    end
    check("abort_start_seen", tx, 1'b0);
    repeat (BIT_CYC * 4 + 2) @(negedge Clock);
    reset = 1'b1;
    @(negedge Clock);
    reset = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_gnt", bus.gnt, 2'b00);
    wait_gnt("reserve", 2'b01, n);
    check("reserve_gap", n, 1);
    bus.req = '0;
    capture("reserve", 8'h5A, -1, 2'b00, 2'b00, 16'h0);

    // Randomized traffic against the round-robin reference.
    reset = 1'b1;
    @(negedge Clock);
    reset = 1'b0;
    @(negedge Clock);
    m_ptr = 0;
    for (int it = 0; it < 14; it++) begin
      pend_req  = 2'($urandom_range(1, 3));
      pend_data = 16'($urandom);
      if (bus.req == 2'b00) begin
        repeat ($urandom_range(0, 9)) @(negedge Clock);
        bus.req      = pend_req;
        bus.req_data = pend_data;
      end
      w     = rr_pick(bus.req, m_ptr);
      m_ptr = (w + 1) % 2;
      eg    = 2'(1 << w);
      eb    = 8'(bus.req_data >> (w * 8));
      wait_gnt($sformatf("rnd%0d", it), eg, n);
      bus.req   = bus.req & ~eg;
      remaining = bus.req;
      newbits   = 2'($urandom_range(0, 3));
      ndata     = bus.req_data;
      if (newbits[0] && !remaining[0]) ndata[7:0]  = 8'($urandom);
      if (newbits[1] && !remaining[1]) ndata[15:8] = 8'($urandom);
      capture($sformatf("rnd%0d", it), eb, $urandom_range(10, 75), 2'($urandom),
              remaining | newbits, ndata);
    end
    bus.req = '0;
    repeat (4) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
